// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

   localparam int INST_W = 32;
   localparam int PC_W   = 32;

   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   // Instructions are word aligned; low byte-offset bits never reach the pc.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
      return a & ~(PC_W'(3));
   endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// ROM, redirect/halt and fetch-stage handshake bundle between the fetch controller and its neighbours.
interface inst_fetch_ctrl_if #(
   parameter int ADDR_W = 6
);
   import fetch_pkg::*;

   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [INST_W-1:0] rom_inst;

   logic              redirect_en;
   logic [PC_W-1:0]   redirect_pc;
   logic              halt;

   logic              if_valid;
   logic              if_ready;
   logic [PC_W-1:0]   if_pc;
   logic [INST_W-1:0] if_inst;

   modport master (
      output rom_ce, rom_addr, if_valid, if_pc, if_inst,
      input  rom_inst, redirect_en, redirect_pc, halt, if_ready
   );

   modport slave (
      input  rom_ce, rom_addr, if_valid, if_pc, if_inst,
      output rom_inst, redirect_en, redirect_pc, halt, if_ready
   );

endinterface

// File: rtl/fetch_pc.sv
// Program counter: reset / redirect / +4 selection, and ROM word-address slice.
// Updates on the clock edge; rom_addr follows the pc register directly.
module fetch_pc
   import fetch_pkg::*;
#(
   parameter int              ADDR_W   = 6,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_en,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              inc,
   output logic [PC_W-1:0]   pc,
   output logic [ADDR_W-1:0] rom_addr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect_en) begin
         pc <= align_pc(redirect_pc);
      end else if (inc) begin
         pc <= pc + PC_W'(4);
      end
   end

   // Natural 32-bit wrap carries straight through to the word address.
   assign rom_addr = pc[ADDR_W+1:2];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns pc, drives the ROM and registers one instruction toward decode.
// One-cycle fetch latency; the output entry holds under !if_ready, redirect squashes it.
module inst_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int              ADDR_W   = 6,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   inst_fetch_ctrl_if.master bus
);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] RUN  = ST_RUN;
   localparam logic [1:0] HALT = ST_HALT;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              load;
   logic [PC_W-1:0]   pc;
   logic [ADDR_W-1:0] rom_addr;
   logic              if_valid;
   logic [PC_W-1:0]   if_pc;
   logic [INST_W-1:0] if_inst;

   fetch_pc #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk         (clk),
      .rst         (rst),
      .redirect_en (bus.redirect_en),
      .redirect_pc (bus.redirect_pc),
      .inc         (load),
      .pc          (pc),
      .rom_addr    (rom_addr)
   );

   assign load = (state == RUN) && !bus.halt && !bus.redirect_en &&
                 (!if_valid || bus.if_ready);

   // Every state, IDLE included, resolves on halt alone; redirect never moves the FSM.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = bus.halt ? HALT : RUN;
         RUN:     state_nxt = bus.halt ? HALT : RUN;
         HALT:    state_nxt = bus.halt ? HALT : RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_valid <= 1'b0;
         if_pc    <= '0;
         if_inst  <= NOP_INST;
      end else if (bus.redirect_en) begin
         if_valid <= 1'b0;
      end else if (load) begin
         if_valid <= 1'b1;
         if_pc    <= pc;
         if_inst  <= bus.rom_inst;
      end else if (if_valid && bus.if_ready) begin
         if_valid <= 1'b0;
      end
   end

   assign bus.rom_ce   = (state == RUN);
   assign bus.rom_addr = rom_addr;
   assign bus.if_valid = if_valid;
   assign bus.if_pc    = if_pc;
   assign bus.if_inst  = if_inst;

endmodule
